// File: rtl/alu_issue_stage.sv
// Decode-to-execute register stage: decodes RV32I, picks ALU operands and operation,
// and holds them for EX under valid/stall/flush control.
module alu_issue_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic                     stall,
   input  logic                     flush,
   output logic                     in_ready,
   input  logic [31:0]              instr,
   input  logic [DATA_WIDTH-1:0]    pc,
   input  logic [DATA_WIDTH-1:0]    rs1_data,
   input  logic [DATA_WIDTH-1:0]    rs2_data,
   input  logic [DATA_WIDTH-1:0]    imm,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     is_branch,
   output logic                     illegal,
   output logic [4:0]               rd_addr
);

   localparam logic [OPCODE_LENGTH-1:0] OP_AND  = 4'b0000;
   localparam logic [OPCODE_LENGTH-1:0] OP_OR   = 4'b0001;
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = 4'b0010;
   localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = 4'b0011;
   localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = 4'b0100;
   localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = 4'b0101;
   localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = 4'b0110;
   localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = 4'b0111;
   localparam logic [OPCODE_LENGTH-1:0] OP_SRA  = 4'b1000;
   localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = 4'b1001;
   localparam logic [OPCODE_LENGTH-1:0] OP_BNE  = 4'b1010;
   localparam logic [OPCODE_LENGTH-1:0] OP_BLT  = 4'b1011;
   localparam logic [OPCODE_LENGTH-1:0] OP_BGE  = 4'b1100;
   localparam logic [OPCODE_LENGTH-1:0] OP_SLTU = 4'b1101;
   localparam logic [OPCODE_LENGTH-1:0] OP_BLTU = 4'b1110;
   localparam logic [OPCODE_LENGTH-1:0] OP_BGEU = 4'b1111;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0]               opcode;
   logic [2:0]               funct3;
   logic [6:0]               funct7;
   logic [DATA_WIDTH-1:0]    shamt_ext;
   logic [DATA_WIDTH-1:0]    link_incr;

   logic [OPCODE_LENGTH-1:0] dec_op;
   logic [DATA_WIDTH-1:0]    dec_a;
   logic [DATA_WIDTH-1:0]    dec_b;
   logic                     dec_branch;
   logic                     dec_illegal;
   logic [4:0]               dec_rd;

   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign funct7    = instr[31:25];
   assign shamt_ext = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
   assign link_incr = DATA_WIDTH'(4);
   assign in_ready  = ~stall;

   always_comb begin
      dec_op      = OP_ADD;
      dec_a       = '0;
      dec_b       = '0;
      dec_branch  = 1'b0;
      dec_illegal = 1'b0;
      dec_rd      = instr[11:7];
      case (opcode)
         OPC_R: begin
            dec_a = rs1_data;
            dec_b = rs2_data;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  3'b000:  dec_op = OP_ADD;
                  3'b001:  dec_op = OP_SLL;
                  3'b010:  dec_op = OP_SLT;
                  3'b011:  dec_op = OP_SLTU;
                  3'b100:  dec_op = OP_XOR;
                  3'b101:  dec_op = OP_SRL;
                  3'b110:  dec_op = OP_OR;
                  default: dec_op = OP_AND;
               endcase
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               dec_op = OP_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               dec_op = OP_SRA;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OPC_I: begin
            dec_a = rs1_data;
            dec_b = imm;
            case (funct3)
               3'b000: dec_op = OP_ADD;
               3'b010: dec_op = OP_SLT;
               3'b011: dec_op = OP_SLTU;
               3'b100: dec_op = OP_XOR;
               3'b110: dec_op = OP_OR;
               3'b111: dec_op = OP_AND;
               3'b001: begin
                  dec_b       = shamt_ext;
                  dec_op      = OP_SLL;
                  dec_illegal = (funct7 != F7_BASE);
               end
               default: begin
                  // funct3 101: shift amount lives in the immediate field, funct7 picks arithmetic
                  dec_b = shamt_ext;
                  if (funct7 == F7_BASE)
                     dec_op = OP_SRL;
                  else if (funct7 == F7_ALT)
                     dec_op = OP_SRA;
                  else
                     dec_illegal = 1'b1;
               end
            endcase
         end
         OPC_LOAD: begin
            dec_a = rs1_data;
            dec_b = imm;
         end
         OPC_STORE: begin
            dec_a  = rs1_data;
            dec_b  = imm;
            dec_rd = 5'd0;
         end
         OPC_BRANCH: begin
            dec_a      = rs1_data;
            dec_b      = rs2_data;
            dec_branch = 1'b1;
            dec_rd     = 5'd0;
            case (funct3)
               3'b000:  dec_op = OP_BEQ;
               3'b001:  dec_op = OP_BNE;
               3'b100:  dec_op = OP_BLT;
               3'b101:  dec_op = OP_BGE;
               3'b110:  dec_op = OP_BLTU;
               3'b111:  dec_op = OP_BGEU;
               default: dec_illegal = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec_b = imm;
         end
         OPC_AUIPC: begin
            dec_a = pc;
            dec_b = imm;
         end
         OPC_JAL, OPC_JALR: begin
            dec_a = pc;
            dec_b = link_incr;
         end
         default: dec_illegal = 1'b1;
      endcase
      // Illegal encodings present a harmless ADD 0+0 with no writeback
      if (dec_illegal) begin
         dec_op     = OP_ADD;
         dec_a      = '0;
         dec_b      = '0;
         dec_branch = 1'b0;
         dec_rd     = 5'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush || (!stall && !in_valid)) begin
         out_valid <= 1'b0;
         SrcA      <= '0;
         SrcB      <= '0;
         Operation <= OP_AND;
         is_branch <= 1'b0;
         illegal   <= 1'b0;
         rd_addr   <= 5'd0;
      end else if (!stall) begin
         out_valid <= 1'b1;
         SrcA      <= dec_a;
         SrcB      <= dec_b;
         Operation <= dec_op;
         is_branch <= dec_branch;
         illegal   <= dec_illegal;
         rd_addr   <= dec_rd;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: hand-encoded RV32I vectors with hand-computed results.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset, in_valid, stall, flush;
   logic        in_ready;
   logic [31:0] instr, pc, rs1_data, rs2_data, imm;
   logic        out_valid, is_branch, illegal;
   logic [31:0] SrcA, SrcB;
   logic [3:0]  Operation;
   logic [4:0]  rd_addr;

   int checks = 0;
   int errors = 0;

   alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
      .in_ready(in_ready), .instr(instr), .pc(pc), .rs1_data(rs1_data),
      .rs2_data(rs2_data), .imm(imm), .out_valid(out_valid), .SrcA(SrcA),
      .SrcB(SrcB), .Operation(Operation), .is_branch(is_branch),
      .illegal(illegal), .rd_addr(rd_addr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] op, input logic br,
                             input logic ill, input logic [4:0] rd);
      check_val({tag, ".valid"}, 32'(out_valid), 32'(v));
      check_val({tag, ".srca"},  SrcA, a);
      check_val({tag, ".srcb"},  SrcB, b);
      check_val({tag, ".op"},    32'(Operation), 32'(op));
      check_val({tag, ".br"},    32'(is_branch), 32'(br));
      check_val({tag, ".ill"},   32'(illegal), 32'(ill));
      check_val({tag, ".rd"},    32'(rd_addr), 32'(rd));
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im, input logic v);
      instr = i; pc = p; rs1_data = r1; rs2_data = r2; imm = im; in_valid = v;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      drive($urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
      tick;
      drive($urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
      stall = 1'b1;
      tick;
      expect_out("reset", 0, 0, 0, 4'b0000, 0, 0, 0);
      check_val("ready_stalled", 32'(in_ready), 32'd0);
      stall = 1'b0;
      #1;
      check_val("ready_free", 32'(in_ready), 32'd1);
      reset = 1'b0;

      drive(32'h402081B3, 32'h100, 32'd10, 32'd3, 32'h0, 1'b1);
      tick;
      expect_out("sub", 1, 32'd10, 32'd3, 4'b0011, 0, 0, 5'd3);

      drive(32'h40435293, 32'h104, 32'h80000000, 32'h0, 32'h404, 1'b1);
      tick;
      expect_out("srai", 1, 32'h80000000, 32'd4, 4'b1000, 0, 0, 5'd5);

      drive(32'h003103B3, 32'h108, 32'd7, 32'd9, 32'h0, 1'b1);
      tick;
      expect_out("add", 1, 32'd7, 32'd9, 4'b0010, 0, 0, 5'd7);

      drive(32'h00000237, 32'h10C, 32'hAAAA, 32'hBBBB, 32'h12345000, 1'b1);
      tick;
      expect_out("lui", 1, 32'd0, 32'h12345000, 4'b0010, 0, 0, 5'd4);

      drive(32'h00000317, 32'h110, 32'hAAAA, 32'hBBBB, 32'h00001000, 1'b1);
      tick;
      expect_out("auipc", 1, 32'h110, 32'h1000, 4'b0010, 0, 0, 5'd6);

      drive(32'h000000EF, 32'h114, 32'hAAAA, 32'hBBBB, 32'h40, 1'b1);
      tick;
      expect_out("jal", 1, 32'h114, 32'd4, 4'b0010, 0, 0, 5'd1);

      drive(32'h00A12423, 32'h118, 32'h2000, 32'h55, 32'h8, 1'b1);
      tick;
      expect_out("sw", 1, 32'h2000, 32'h8, 4'b0010, 0, 0, 5'd0);

      drive(32'h40331293, 32'h11C, 32'h77, 32'h88, 32'h403, 1'b1);
      tick;
      expect_out("slli_bad", 1, 0, 0, 4'b0010, 0, 1, 5'd0);

      drive(32'h0020A063, 32'h120, 32'd1, 32'd2, 32'h0, 1'b1);
      tick;
      expect_out("br_bad", 1, 0, 0, 4'b0010, 0, 1, 5'd0);

      drive(32'h4020C1B3, 32'h124, 32'd1, 32'd2, 32'h0, 1'b1);
      tick;
      expect_out("r_bad", 1, 0, 0, 4'b0010, 0, 1, 5'd0);

      drive(32'h0000050B, 32'h128, 32'd5, 32'd6, 32'h9, 1'b1);
      tick;
      expect_out("custom", 1, 0, 0, 4'b0010, 0, 1, 5'd0);

      drive(32'h0020E463, 32'h12C, 32'd1, 32'd2, 32'h8, 1'b1);
      tick;
      expect_out("bltu", 1, 32'd1, 32'd2, 4'b1110, 1, 0, 5'd0);

      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(32'h402081B3 + 32'(k), 32'h200, 32'd50 + 32'(k), 32'd60, 32'h1, (k != 1));
         tick;
         expect_out("stall_hold", 1, 32'd1, 32'd2, 4'b1110, 1, 0, 5'd0);
      end
      stall = 1'b0;

      drive(32'h003103B3, 32'h130, 32'd11, 32'd12, 32'h0, 1'b1);
      tick;
      expect_out("add2", 1, 32'd11, 32'd12, 4'b0010, 0, 0, 5'd7);
      stall = 1'b1; flush = 1'b1;
      tick;
      expect_out("flush_stall", 0, 0, 0, 4'b0000, 0, 0, 5'd0);
      stall = 1'b0; flush = 1'b0;

      drive(32'h402081B3, 32'h134, 32'd20, 32'd4, 32'h0, 1'b0);
      tick;
      expect_out("not_valid", 0, 0, 0, 4'b0000, 0, 0, 5'd0);

      drive(32'h402081B3, 32'h138, 32'd20, 32'd4, 32'h0, 1'b1);
      tick;
      expect_out("sub2", 1, 32'd20, 32'd4, 4'b0011, 0, 0, 5'd3);
      stall = 1'b1; reset = 1'b1;
      tick;
      expect_out("reset_stall", 0, 0, 0, 4'b0000, 0, 0, 5'd0);
      reset = 1'b0; stall = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute pipeline stage that drives the ALU's SrcA, SrcB and 4-bit Operation inputs.
- Decodes a RV32I instruction, selects operands (rs1/PC/zero, rs2/imm/shamt/4) and registers them for the EX stage.
- Supports valid, stall and flush control, and flags illegal ALU encodings.
- Sits between the register-file read and the ALU.

Parameters:
DATA_WIDTH, 32, operand/PC width
OPCODE_LENGTH, 4, width of the Operation code

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  decoded instruction present this cycle
stall  input  1  hold output registers
flush  input  1  kill contents (branch taken / trap)
in_ready  output  1  equals ~stall, combinational
instr  input  32  raw instruction
pc  input  DATA_WIDTH  instruction address
rs1_data  input  DATA_WIDTH  register-file read port 1
rs2_data  input  DATA_WIDTH  register-file read port 2
imm  input  DATA_WIDTH  sign-extended immediate, already formatted per type
out_valid  output  1  EX-stage contents valid
SrcA  output  DATA_WIDTH  ALU operand A
SrcB  output  DATA_WIDTH  ALU operand B
Operation  output  OPCODE_LENGTH  ALU operation code
is_branch  output  1  instruction is a conditional branch
illegal  output  1  unsupported encoding decoded
rd_addr  output  5  destination register (0 for branch/store)

Behaviour:
- Reset: all outputs except in_ready are zero. This includes out_valid, SrcA, SrcB, Operation=0000, is_branch, illegal and rd_addr.
- Register update priority per rising edge is reset > flush > stall > load:
  - flush: every output register cleared exactly as on reset.
  - stall (no flush): all output registers hold.
  - load: registers take the decode of the current inputs; out_valid <= in_valid.
  - in_valid=0 on load: out_valid=0 and the other fields are cleared.
- Latency: 1 cycle from accepted input to outputs.
- Operation codes: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, BEQ 1001, BNE 1010, BLT 1011, BGE 1100, SLTU 1101, BLTU 1110, BGEU 1111.
- Decode by opcode instr[6:0]:
  - 0110011 R-type: SrcA=rs1, SrcB=rs2.
    - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - funct7=0100000: funct3 000 SUB, 101 SRA; any other funct3 is illegal.
    - Any other funct7 is illegal.
  - 0010011 I-type: SrcA=rs1, SrcB=imm.
    - funct3 mapping as R-type, with no SUB.
    - funct3 001/101 are shifts: SrcB = zero-extended instr[24:20]. funct7 selects SRL/SRA as in R-type. Slli with funct7≠0 is illegal.
  - 0000011 load / 0100011 store: ADD, SrcA=rs1, SrcB=imm. Store forces rd_addr=0.
  - 1100011 branch: SrcA=rs1, SrcB=rs2, is_branch=1, rd_addr=0.
    - funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
    - funct3 010/011 are illegal.
  - 0110111 LUI: ADD, SrcA=0, SrcB=imm.
  - 0010111 AUIPC: ADD, SrcA=pc, SrcB=imm.
  - 1101111 JAL / 1100111 JALR: ADD, SrcA=pc, SrcB=4 (link value).
  - Any other opcode is illegal.
- On illegal: Operation=ADD, SrcA=SrcB=0, rd_addr=0, is_branch=0, illegal=1. out_valid still follows in_valid so the trap logic sees the flag.
- rd_addr = instr[11:7] except where forced to 0 above.
- Simultaneous flush+stall: flush wins. A stall never blocks a flush.
- Reset asserted mid-stall clears the stage on that edge.

Test Plan:
- Reset held 2 cycles with random inputs -> all outputs 0 and Operation=0000; in_ready tracks ~stall.
- instr=0x402081B3 (sub x3,x1,x2), rs1=10, rs2=3, in_valid=1 -> next cycle out_valid=1, SrcA=10, SrcB=3, Operation=0011, rd_addr=3, illegal=0.
- instr=0x40435293 (srai x5,x6,4), rs1=0x80000000, imm=0x404 -> SrcB=4 (not imm), Operation=1000, rd_addr=5.
- Branch funct3=110 (bltu), rs1=1, rs2=2 -> Operation=1110, is_branch=1, rd_addr=0. Then apply stall 3 cycles with changed inputs -> outputs unchanged throughout.
- Load the stage, then assert stall=1 and flush=1 together -> next cycle out_valid=0, all fields 0.
- instr opcode=0001011 (custom), in_valid=1 -> out_valid=1, illegal=1, Operation=0010, SrcA=SrcB=0.
